// File: rtl/chimera_cluster_boot_seq.sv
// Per-cluster boot sequencer: clock-gate, reset, boot address and msip
// bring-up, run until end-of-computation, then teardown or abort.
module chimera_cluster_boot_seq #(
  parameter int unsigned NrCores    = 2,
  parameter int unsigned ClkEnDelay = 4,
  parameter int unsigned MsipDelay  = 2,
  parameter int unsigned RstHold    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_valid_i,
  output logic               start_ready_o,
  input  logic [31:0]        boot_addr_i,
  input  logic [NrCores-1:0] core_mask_i,
  input  logic               bypass_i,
  input  logic               abort_i,
  input  logic               eoc_i,
  input  logic               irq_clr_i,
  output logic               clu_clk_en_o,
  output logic               clu_rst_no,
  output logic [31:0]        boot_addr_o,
  output logic               widemem_bypass_o,
  output logic [NrCores-1:0] msip_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o,
  output logic               irq_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLKEN,
    S_RSTREL,
    S_WAKE,
    S_RUN,
    S_DRAIN,
    S_ABORT
  } state_e;

  localparam logic [7:0] LdClkEn = 8'(ClkEnDelay - 1);
  localparam logic [7:0] LdMsip  = 8'(MsipDelay - 1);
  localparam logic [7:0] LdHold  = 8'(RstHold - 1);

  state_e             r_state;
  logic [7:0]         r_cnt;
  logic [NrCores-1:0] r_mask;
  logic [NrCores-1:0] r_msip;
  logic [31:0]        r_boot_addr;
  logic               r_bypass;
  logic               r_clk_en;
  logic               r_rst_n;
  logic               r_busy;
  logic               r_done;
  logic               r_aborted;
  logic               r_irq;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_eoc_q;

  logic w_eoc_rise;
  logic w_cnt_zero;
  logic w_abort;
  logic w_fin_done;
  logic w_fin_abort;

  always_comb begin
    w_eoc_rise  = r_sync2 & ~r_eoc_q;
    w_cnt_zero  = (r_cnt == 8'd0);
    w_abort     = abort_i & (r_state != S_IDLE)
                & (r_state != S_ABORT);
    w_fin_done  = (r_state == S_DRAIN) & ~w_abort;
    w_fin_abort = (r_state == S_ABORT) & w_cnt_zero;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_mask      <= '0;
      r_msip      <= '0;
      r_boot_addr <= 32'd0;
      r_bypass    <= 1'b0;
      r_clk_en    <= 1'b0;
      r_rst_n     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_irq       <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_eoc_q     <= 1'b0;
    end else begin
      r_sync1   <= eoc_i;
      r_sync2   <= r_sync1;
      r_eoc_q   <= r_sync2;
      r_done    <= w_fin_done;
      r_aborted <= w_fin_abort;
      // Registered done/aborted also set, so a clear seen with the pulse loses.
      if (w_fin_done | w_fin_abort | r_done | r_aborted)
        r_irq <= 1'b1;
      else if (irq_clr_i)
        r_irq <= 1'b0;
      if (w_abort) begin
        r_state  <= S_ABORT;
        r_cnt    <= LdHold;
        r_rst_n  <= 1'b0;
        r_clk_en <= 1'b1;
        r_msip   <= '0;
        r_busy   <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start_valid_i) begin
              r_state     <= S_CLKEN;
              r_cnt       <= LdClkEn;
              r_boot_addr <= boot_addr_i;
              r_mask      <= core_mask_i;
              r_bypass    <= bypass_i;
              r_clk_en    <= 1'b1;
              r_rst_n     <= 1'b0;
              r_busy      <= 1'b1;
            end
          end
          S_CLKEN: begin
            if (w_cnt_zero) begin
              r_state <= S_RSTREL;
              r_cnt   <= LdMsip;
              r_rst_n <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_RSTREL: begin
            if (w_cnt_zero) begin
              r_state <= S_WAKE;
              r_msip  <= r_mask;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_WAKE: begin
            r_state <= S_RUN;
            r_msip  <= '0;
          end
          S_RUN: begin
            if (w_eoc_rise) begin
              r_state <= S_DRAIN;
              r_rst_n <= 1'b0;
            end
          end
          S_DRAIN: begin
            r_state  <= S_IDLE;
            r_clk_en <= 1'b0;
            r_busy   <= 1'b0;
          end
          S_ABORT: begin
            if (w_cnt_zero) begin
              r_state  <= S_IDLE;
              r_clk_en <= 1'b0;
              r_busy   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign start_ready_o    = (r_state == S_IDLE);
  assign clu_clk_en_o     = r_clk_en;
  assign clu_rst_no       = r_rst_n;
  assign boot_addr_o      = r_boot_addr;
  assign widemem_bypass_o = r_bypass;
  assign msip_o           = r_msip;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign aborted_o        = r_aborted;
  assign irq_o            = r_irq;

endmodule

// File: tb/tb_chimera_cluster_boot_seq.sv
// Directed bench for chimera_cluster_boot_seq: start, run, abort,
// eoc edge handling, mask=0, mid-sequence reset and irq clear.
module tb_chimera_cluster_boot_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv = 1'b0;
  logic        ready;
  logic [31:0] addr = 32'd0;
  logic [1:0]  mask = 2'd0;
  logic        byp = 1'b0;
  logic        abrt = 1'b0;
  logic        eoc = 1'b0;
  logic        clr = 1'b0;
  logic        en;
  logic        rn;
  logic [31:0] baddr;
  logic        bsel;
  logic [1:0]  msip;
  logic        busy;
  logic        done;
  logic        abd;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  chimera_cluster_boot_seq dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_valid_i    (sv),
    .start_ready_o    (ready),
    .boot_addr_i      (addr),
    .core_mask_i      (mask),
    .bypass_i         (byp),
    .abort_i          (abrt),
    .eoc_i            (eoc),
    .irq_clr_i        (clr),
    .clu_clk_en_o     (en),
    .clu_rst_no       (rn),
    .boot_addr_o      (baddr),
    .widemem_bypass_o (bsel),
    .msip_o           (msip),
    .busy_o           (busy),
    .done_o           (done),
    .aborted_o        (abd),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_cyc(input string t, input logic e_en,
                         input logic e_rn, input logic [1:0] e_ms,
                         input logic e_dn, input logic e_ab,
                         input logic e_by, input logic e_irq);
    chk($sformatf("%s en c%0d", t, cyc), 32'(en), 32'(e_en));
    chk($sformatf("%s rn c%0d", t, cyc), 32'(rn), 32'(e_rn));
    chk($sformatf("%s msip c%0d", t, cyc), 32'(msip), 32'(e_ms));
    chk($sformatf("%s done c%0d", t, cyc), 32'(done), 32'(e_dn));
    chk($sformatf("%s abd c%0d", t, cyc), 32'(abd), 32'(e_ab));
    chk($sformatf("%s busy c%0d", t, cyc), 32'(busy), 32'(e_by));
    chk($sformatf("%s rdy c%0d", t, cyc), 32'(ready), 32'(!e_by));
    chk($sformatf("%s irq c%0d", t, cyc), 32'(irq), 32'(e_irq));
  endtask

  task automatic start(input logic [31:0] a, input logic [1:0] m,
                       input logic b);
    addr = a;
    mask = m;
    byp  = b;
    sv   = 1'b1;
    tick();
    sv   = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk_cyc("rst", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst addr", baddr, 32'd0);
    chk("rst byp", 32'(bsel), 32'd0);

    // Normal run, eoc rise at 20, irq clear coincident with done
    cyc = 0;
    start(32'h3000_0000, 2'b11, 1'b1);
    while (cyc < 27) begin
      chk_cyc("t1", cyc < 24, cyc >= 5 && cyc < 23,
              (cyc == 7) ? 2'b11 : 2'b00, cyc == 24, 1'b0,
              cyc < 24, cyc == 24 || cyc == 25);
      chk($sformatf("t1 addr c%0d", cyc), baddr, 32'h3000_0000);
      chk($sformatf("t1 byp c%0d", cyc), 32'(bsel), 32'd1);
      eoc = (cyc >= 20);
      clr = (cyc == 24 || cyc == 25);
      tick();
    end
    eoc = 1'b0;
    clr = 1'b0;
    repeat (3) tick();

    // Abort in RUN at cycle 12
    cyc = 0;
    start(32'h8000_1000, 2'b01, 1'b0);
    while (cyc < 23) begin
      chk_cyc("t2", cyc < 21, cyc >= 5 && cyc < 13,
              (cyc == 7) ? 2'b01 : 2'b00, 1'b0, cyc == 21,
              cyc < 21, cyc >= 21);
      abrt = (cyc == 12);
      tick();
    end
    chk("t2 addr", baddr, 32'h8000_1000);
    chk("t2 byp", 32'(bsel), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2 irqclr", 32'(irq), 32'd0);

    // eoc already high: no completion until a fresh rise at 30
    eoc = 1'b1;
    repeat (4) tick();
    cyc = 0;
    start(32'h1234_5678, 2'b11, 1'b1);
    while (cyc < 36) begin
      chk_cyc("t3", cyc < 34, cyc >= 5 && cyc < 33,
              (cyc == 7) ? 2'b11 : 2'b00, cyc == 34, 1'b0,
              cyc < 34, cyc >= 34);
      eoc = (cyc < 20) || (cyc >= 30);
      tick();
    end
    eoc = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();

    // mask=0, back-to-back start at 19, then reset during CLKEN
    cyc = 0;
    start(32'hA5A5_0000, 2'b00, 1'b0);
    while (cyc < 20) begin
      chk_cyc("t4", cyc < 19, cyc >= 5 && cyc < 18, 2'b00,
              cyc == 19, 1'b0, cyc < 19, cyc >= 19);
      eoc = (cyc >= 15);
      if (cyc == 19) begin
        eoc  = 1'b0;
        addr = 32'h0BAD_0000;
        mask = 2'b10;
        byp  = 1'b1;
        sv   = 1'b1;
      end
      tick();
    end
    sv = 1'b0;
    chk_cyc("t5", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5 addr", baddr, 32'h0BAD_0000);
    chk("t5 byp", 32'(bsel), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cyc("t5 rst", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5 rst addr", baddr, 32'd0);
    chk("t5 rst byp", 32'(bsel), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
